fpga_exit_reporter: RTL and testbench



---
 rtl/fpga_exit_reporter_pkg.sv | 19 +
 rtl/fpga_exit_reporter_uart.sv | 103 ++++++++++
 rtl/fpga_exit_reporter.sv | 101 ++++++++++
 tb/tb_fpga_exit_reporter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_exit_reporter_pkg.sv
// rtl/fpga_exit_reporter_pkg.sv - shared types and constants for the exit reporter
package fpga_exit_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BYTES = 6;
  localparam int LAST_BYTE   = FRAME_BYTES - 1;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hE5;

  function automatic logic [7:0] xor_checksum(input logic [31:0] value);
    return value[7:0] ^ value[15:8] ^ value[23:16] ^ value[31:24];
  endfunction

endpackage

// File: rtl/fpga_exit_reporter_uart.sv
// rtl/fpga_exit_reporter_uart.sv - 8N1 byte serializer with valid/ready input
// ready is offered in IDLE and on the last stop-bit cycle, so bytes chain with no gap.
module uart_tx_byte
  import fpga_exit_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_tvalid_i,
  input  logic [7:0] s_tdata_i,
  output logic       s_tready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       idle_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, busy_q, done_q;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign s_tready_o = (state_q == IDLE) | ((state_q == STOP) & bit_end);
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign idle_o     = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (s_tvalid_i) begin
          state_d = START;
          cnt_d   = '0;
          shreg_d = s_tdata_i;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (s_tvalid_i) begin
            state_d = START;
            shreg_d = s_tdata_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and status are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shreg_q[0] : 1'b1;
      busy_q  <= (state_q != IDLE);
      done_q  <= busy_q & (state_q == IDLE);
    end
  end

endmodule

// File: rtl/fpga_exit_reporter.sv
// rtl/fpga_exit_reporter.sv - captures the SoC exit word and sends it as a 6-byte UART frame
// Frame: sync, value bytes LSB first, XOR checksum.
module fpga_exit_reporter
  import fpga_exit_reporter_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        tx_enable_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  logic        valid_q;
  logic [31:0] value_q, value_d;
  logic [2:0]  idx_q, idx_d;
  logic        active_q, active_d;
  logic        overrun_q, overrun_d;

  logic        rise, accept, tx_idle, tx_busy, tx_done;
  logic        s_tvalid, s_tready, handshake;
  logic [2:0]  byte_sel;
  logic [7:0]  s_tdata;

  assign rise      = exit_valid_i & ~valid_q & tx_enable_i;
  // The done cycle still counts as busy, so a rise there is an overrun.
  assign accept    = rise & tx_idle & ~tx_busy & ~tx_done;
  assign s_tvalid  = accept | active_q;
  assign handshake = s_tvalid & s_tready;
  assign byte_sel  = accept ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    s_tdata = SYNC_BYTE;
    case (byte_sel)
      3'd1:    s_tdata = value_q[7:0];
      3'd2:    s_tdata = value_q[15:8];
      3'd3:    s_tdata = value_q[23:16];
      3'd4:    s_tdata = value_q[31:24];
      3'd5:    s_tdata = xor_checksum(value_q);
      default: s_tdata = SYNC_BYTE;
    endcase
  end

  always_comb begin
    value_d   = value_q;
    idx_d     = idx_q;
    active_d  = active_q;
    overrun_d = overrun_q | (rise & ~accept);
    if (accept) begin
      value_d  = exit_value_i;
      idx_d    = 3'd0;
      active_d = 1'b1;
    end else if (handshake && idx_q < 3'(LAST_BYTE)) begin
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'(LAST_BYTE - 1)) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      value_q   <= 32'h0;
      idx_q     <= 3'd0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= exit_valid_i;
      value_q   <= value_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_tvalid_i(s_tvalid),
    .s_tdata_i (s_tdata),
    .s_tready_o(s_tready),
    .tx_o      (uart_tx_o),
    .busy_o    (tx_busy),
    .done_o    (tx_done),
    .idle_o    (tx_idle)
  );

  assign busy_o    = tx_busy;
  assign done_o    = tx_done;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// tb/tb_fpga_exit_reporter.sv - directed bench with a UART-decoding scoreboard
module tb_fpga_exit_reporter;

  localparam int CPB = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = 32'h0;
  logic        tx_enable_i = 1'b1;
  logic        uart_tx_o, busy_o, done_o, overrun_o;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  logic [7:0] mon_byte;
  logic       mon_stop;
  bit         mon_abort;

  always #5 clk_i = ~clk_i;

  fpga_exit_reporter #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hE5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .tx_enable_i (tx_enable_i),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overrun_o   (overrun_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_frame(input logic [31:0] v);
    sb.push_back(8'hE5);
    for (int i = 0; i < 4; i++) sb.push_back(v[8*i +: 8]);
    sb.push_back(v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24]);
  endtask

  task automatic pulse(input logic [31:0] v);
    exit_value_i = v;
    exit_valid_i = 1'b1;
    tick();
    exit_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ticks(2);
    rst_i = 1'b0;
    ticks(2);
  endtask

  task automatic wait_frame(input int exp_lat, input bit poke_on_done);
    int n;
    int len;
    n = 0;
    len = 0;
    while (busy_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("start_latency", n, exp_lat);
    check("start_bit", uart_tx_o, 1'b0);
    while (busy_o === 1'b1 && len < 1000) begin
      tick();
      len++;
    end
    check("frame_len", len, 60 * CPB);
    check("done_pulse", done_o, 1'b1);
    if (poke_on_done) exit_valid_i = 1'b1;
    tick();
    check("done_width", done_o, 1'b0);
    exit_valid_i = 1'b0;
  endtask

  // Line decoder: samples each bit one cycle into its period, skips bytes cut by reset.
  always begin
    @(negedge clk_i);
    if (!rst_i && uart_tx_o === 1'b0) begin
      mon_abort = 1'b0;
      mon_byte  = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat ((i == 0) ? CPB + 1 : CPB) @(negedge clk_i);
        if (rst_i) mon_abort = 1'b1;
        mon_byte[i] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk_i);
      if (rst_i) mon_abort = 1'b1;
      mon_stop = uart_tx_o;
      if (!mon_abort) begin
        check("stop_bit", mon_stop, 1'b1);
        check("sb_has_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("uart_byte", mon_byte, sb.pop_front());
      end
    end
  end

  initial begin
    ticks(3);
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    rst_i = 1'b0;
    ticks(2);

    sb.push_back(8'hE5); sb.push_back(8'h01); sb.push_back(8'h00);
    sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01);
    pulse(32'h0000_0001);
    wait_frame(1, 1'b0);
    ticks(5);
    check("basic_drained", sb.size(), 0);

    sb.push_back(8'hE5); sb.push_back(8'hEF); sb.push_back(8'hBE);
    sb.push_back(8'hAD); sb.push_back(8'hDE); sb.push_back(8'h22);
    pulse(32'hDEAD_BEEF);
    wait_frame(1, 1'b0);
    ticks(5);
    check("cksum_drained", sb.size(), 0);
    check("no_overrun_yet", overrun_o, 1'b0);

    push_frame(32'h1234_5678);
    pulse(32'h1234_5678);
    ticks(48);
    pulse(32'hCAFE_F00D);
    tick();
    check("overrun_set", overrun_o, 1'b1);
    for (int n = 0; n < 1000 && busy_o === 1'b1; n++) tick();
    ticks(100);
    check("overrun_no_second", busy_o, 1'b0);
    check("overrun_sticky", overrun_o, 1'b1);
    check("overrun_drained", sb.size(), 0);

    do_reset();
    check("reset_clears_overrun", overrun_o, 1'b0);
    push_frame(32'hA5A5_0F0F);
    pulse(32'hA5A5_0F0F);
    wait_frame(1, 1'b1);
    ticks(2);
    check("done_cycle_overrun", overrun_o, 1'b1);
    ticks(60);
    check("done_cycle_no_frame", busy_o, 1'b0);
    check("done_cycle_drained", sb.size(), 0);

    do_reset();
    tx_enable_i = 1'b0;
    pulse(32'h0000_0055);
    ticks(20);
    check("gated_busy", busy_o, 1'b0);
    check("gated_overrun", overrun_o, 1'b0);
    exit_valid_i = 1'b1;
    ticks(3);
    tx_enable_i = 1'b1;
    ticks(20);
    check("enable_no_edge_busy", busy_o, 1'b0);
    check("enable_no_edge_overrun", overrun_o, 1'b0);
    exit_valid_i = 1'b0;
    ticks(2);

    exit_value_i = 32'h0BAD_F00D;
    push_frame(32'h0BAD_F00D);
    exit_valid_i = 1'b1;
    tick();
    ticks(90);
    rst_i = 1'b1;
    #1;
    check("midrst_tx", uart_tx_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_overrun", overrun_o, 1'b0);
    ticks(50);
    sb.delete();
    exit_value_i = 32'h8765_4321;
    push_frame(32'h8765_4321);
    rst_i = 1'b0;
    wait_frame(2, 1'b0);
    ticks(5);
    check("level_frame_drained", sb.size(), 0);
    exit_valid_i = 1'b0;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
